// File: rtl/hlu_ctrl_pkg.sv
// Shared encodings for the HI/LO unit issue controller: opcodes, HLU start
// commands and FSM states.
package hlu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } hlu_op_e;

    localparam logic [3:0] HLU_NONE      = 4'b0000;
    localparam logic [3:0] HLU_START_MUL = 4'b0001;
    localparam logic [3:0] HLU_START_DIV = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2
    } hlu_state_e;

endpackage

// File: rtl/hlu_ctrl_watchdog.sv
// Watchdog for a hung HLU: counts cycles with an operation in flight and
// raises a sticky error on timeout or on a start the HLU never acknowledged.
module hlu_watchdog #(
    parameter int unsigned WD_LIMIT = 31
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic lost_i,
    output logic timeout_o,
    output logic err_o
);

    localparam int unsigned WDW = (WD_LIMIT < 1) ? 1 : $clog2(WD_LIMIT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(WD_LIMIT);

    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    assign timeout_o = active_i && (wd_q == WD_MAX);
    assign err_o     = err_q;

    always_comb begin
        wd_d  = '0;
        if (active_i && !timeout_o) begin
            wd_d = wd_q + 1'b1;
        end
        err_d = err_q | timeout_o | lost_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/hlu_ctrl.sv
// Pipeline-side issue/interlock controller for the HI/LO unit: decodes E-stage
// HLU ops, pulses HLU commands, stalls while the HLU is armed/busy.
module hlu_ctrl
    import hlu_ctrl_pkg::*;
#(
    parameter int unsigned WD_LIMIT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opValid,
    input  logic [2:0]  opCode,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    input  logic        hluBusy,
    input  logic [31:0] hluResult,
    output logic [31:0] hluA,
    output logic [31:0] hluB,
    output logic [3:0]  hluType,
    output logic        hluUnsigned,
    output logic        hluDst,
    output logic        hluWrite,
    output logic        stall,
    output logic        rdValid,
    output logic [31:0] rdData,
    output logic [31:0] stallCount,
    output logic        err
);

    hlu_state_e  state_q, state_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    hlu_op_e     op;
    logic        hlu_op;
    logic        accept;
    logic        start;
    logic        wd_active;
    logic        wd_lost;
    logic        wd_timeout;

    assign op     = hlu_op_e'(opCode);
    assign hlu_op = opValid;

    // Reset gating keeps stall low while the synchronously-reset HLU may
    // still be reporting busy from before the reset.
    assign stall  = !reset && hlu_op && ((state_q == ST_ARMED) || hluBusy);
    assign accept = !reset && hlu_op && !stall;

    always_comb begin
        hluA        = '0;
        hluB        = '0;
        hluType     = HLU_NONE;
        hluUnsigned = 1'b0;
        hluDst      = 1'b0;
        hluWrite    = 1'b0;
        rdValid     = 1'b0;
        rdData      = '0;
        start       = 1'b0;
        if (accept) begin
            unique case (op)
                OP_MULT, OP_MULTU: begin
                    hluType     = HLU_START_MUL;
                    hluA        = rsData;
                    hluB        = rtData;
                    hluUnsigned = opCode[0];
                    start       = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    hluType     = HLU_START_DIV;
                    hluA        = rsData;
                    hluB        = rtData;
                    hluUnsigned = opCode[0];
                    start       = 1'b1;
                end
                OP_MTHI, OP_MTLO: begin
                    hluWrite = 1'b1;
                    hluA     = rsData;
                    hluDst   = (op == OP_MTHI);
                end
                OP_MFHI, OP_MFLO: begin
                    hluDst  = (op == OP_MFHI);
                    rdData  = hluResult;
                    rdValid = 1'b1;
                end
            endcase
        end
    end

    // BUSY with busy already low behaves as IDLE, so a start can re-arm directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ARMED;
            ST_ARMED: state_d = hluBusy ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (!hluBusy) begin
                    state_d = start ? ST_ARMED : ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (wd_timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wd_active  = (state_q == ST_ARMED) || ((state_q == ST_BUSY) && hluBusy);
    assign wd_lost    = (state_q == ST_ARMED) && !hluBusy;
    assign stallCount = stall_cnt_q;

    hlu_watchdog #(
        .WD_LIMIT (WD_LIMIT)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_i     (reset),
        .active_i  (wd_active),
        .lost_i    (wd_lost),
        .timeout_o (wd_timeout),
        .err_o     (err)
    );

endmodule

// File: tb/tb_hlu_ctrl.sv
// Scoreboard bench for hlu_ctrl with a behavioural HLU (multiply 6 cycles,
// divide 11 cycles) that can also be made to lose starts or hang busy.
module tb_hlu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        opValid;
    logic [2:0]  opCode;
    logic [31:0] rsData, rtData;
    logic        hluBusy;
    logic [31:0] hluResult;
    logic [31:0] hluA, hluB;
    logic [3:0]  hluType;
    logic        hluUnsigned, hluDst, hluWrite;
    logic        stall, rdValid;
    logic [31:0] rdData, stallCount;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    logic [3:0]  cap_type;
    logic [31:0] cap_a, cap_b;
    logic        cap_uns, cap_dst, cap_write;

    // 0 normal, 1 never acknowledges a start, 2 busy stuck high after a start
    int          mode = 0;

    always #5 clk = ~clk;

    hlu_ctrl #(.WD_LIMIT(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .opValid     (opValid),
        .opCode      (opCode),
        .rsData      (rsData),
        .rtData      (rtData),
        .hluBusy     (hluBusy),
        .hluResult   (hluResult),
        .hluA        (hluA),
        .hluB        (hluB),
        .hluType     (hluType),
        .hluUnsigned (hluUnsigned),
        .hluDst      (hluDst),
        .hluWrite    (hluWrite),
        .stall       (stall),
        .rdValid     (rdValid),
        .rdData      (rdData),
        .stallCount  (stallCount),
        .err         (err)
    );

    // Behavioural HLU with synchronous reset
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [31:0] hi = '0, lo = '0;
    logic [31:0] pend_hi, pend_lo;
    logic [63:0] prod;

    assign hluBusy   = busy;
    assign hluResult = hluDst ? hi : lo;

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= 0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (hluWrite) begin
                if (hluDst) hi <= hluA;
                else        lo <= hluA;
            end
            if (hluType != 4'b0000) begin
                if (mode == 0) begin
                    busy <= 1'b1;
                    if (hluType == 4'b0001) begin
                        cnt <= 6;
                        if (hluUnsigned) prod = {32'd0, hluA} * {32'd0, hluB};
                        else prod = $signed({{32{hluA[31]}}, hluA}) * $signed({{32{hluB[31]}}, hluB});
                        pend_hi <= prod[63:32];
                        pend_lo <= prod[31:0];
                    end else begin
                        cnt <= 11;
                        if (hluB == 32'd0) begin
                            pend_hi <= hi;
                            pend_lo <= lo;
                        end else if (hluUnsigned) begin
                            pend_hi <= hluA % hluB;
                            pend_lo <= hluA / hluB;
                        end else begin
                            pend_hi <= $signed(hluA) % $signed(hluB);
                            pend_lo <= $signed(hluA) / $signed(hluB);
                        end
                    end
                end else if (mode == 2) begin
                    busy <= 1'b1;
                    cnt  <= 0;
                end
            end else if (busy && mode == 0) begin
                if (cnt == 1) begin
                    busy <= 1'b0;
                    hi   <= pend_hi;
                    lo   <= pend_lo;
                end
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every read the DUT presents is matched against the scoreboard
    always @(negedge clk) begin
        if (rdValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", rdData);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                if (rdData !== e) begin
                    errors++;
                    $display("FAIL rdData: got 0x%08h expected 0x%08h", rdData, e);
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int exp_stalls);
        int stalls;
        bit leak;
        stalls  = 0;
        leak    = 1'b0;
        opValid = 1'b1;
        opCode  = op;
        rsData  = rs;
        rtData  = rt;
        @(negedge clk);
        while (stall && stalls < 200) begin
            stalls++;
            if (hluWrite || hluType != 4'b0000 || rdValid) leak = 1'b1;
            @(negedge clk);
        end
        cap_type  = hluType;
        cap_a     = hluA;
        cap_b     = hluB;
        cap_uns   = hluUnsigned;
        cap_dst   = hluDst;
        cap_write = hluWrite;
        chk({name, "_stalls"}, stalls, exp_stalls);
        if (exp_stalls > 0) chk({name, "_quiet_while_stalled"}, {31'd0, leak}, 32'd0);
        @(posedge clk);
        #1;
        opValid = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        opValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int k;
        reset   = 1'b1;
        opValid = 1'b1;
        opCode  = 3'd5;
        rsData  = '0;
        rtData  = '0;
        #2;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_rdValid", {31'd0, rdValid}, 32'd0);
        chk("reset_stallCount", stallCount, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        do_reset();

        // MULT 7 x -3, then reads
        do_op("mult", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        chk("mult_type", {28'd0, cap_type}, 32'h1);
        chk("mult_a", cap_a, 32'd7);
        chk("mult_b", cap_b, 32'hFFFF_FFFD);
        chk("mult_uns", {31'd0, cap_uns}, 32'd0);
        exp_q.push_back(32'hFFFF_FFEB);
        do_op("mflo_after_mult", 3'd5, '0, '0, 6);
        exp_q.push_back(32'hFFFF_FFFF);
        do_op("mfhi_after_mult", 3'd4, '0, '0, 0);
        chk("stallCount_6", stallCount, 32'd6);

        // DIVU 100 / 7
        do_op("divu", 3'd3, 32'd100, 32'd7, 0);
        chk("divu_type", {28'd0, cap_type}, 32'h2);
        chk("divu_uns", {31'd0, cap_uns}, 32'd1);
        exp_q.push_back(32'd2);
        do_op("mfhi_after_divu", 3'd4, '0, '0, 11);
        exp_q.push_back(32'd14);
        do_op("mflo_after_divu", 3'd5, '0, '0, 0);

        // MTLO then divide by zero leaves LO intact
        do_op("mtlo", 3'd7, 32'h1234, '0, 0);
        chk("mtlo_write", {31'd0, cap_write}, 32'd1);
        chk("mtlo_dst", {31'd0, cap_dst}, 32'd0);
        do_op("div0", 3'd2, 32'd5, 32'd0, 0);
        exp_q.push_back(32'h1234);
        do_op("mflo_after_div0", 3'd5, '0, '0, 11);

        // MTHI presented while a multiply is armed
        do_op("mult2", 3'd0, 32'd2, 32'd3, 0);
        do_op("mthi_blocked", 3'd6, 32'hABCD, '0, 6);
        chk("mthi_dst", {31'd0, cap_dst}, 32'd1);
        exp_q.push_back(32'hABCD);
        do_op("mfhi_after_mthi", 3'd4, '0, '0, 0);
        exp_q.push_back(32'd6);
        do_op("mflo_after_mult2", 3'd5, '0, '0, 0);
        chk("stallCount_34", stallCount, 32'd34);

        // Start lost: busy never rises
        do_reset();
        mode = 1;
        do_op("mult_lost", 3'd0, 32'd1, 32'd1, 0);
        @(negedge clk);
        chk("lost_err_before", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        chk("lost_err_after", {31'd0, err}, 32'd1);
        exp_q.push_back(32'd0);
        do_op("mflo_after_lost", 3'd5, '0, '0, 0);

        // Busy stuck high: watchdog fires after WD_LIMIT+1 edges
        do_reset();
        mode = 2;
        do_op("mult_hang", 3'd0, 32'd1, 32'd1, 0);
        k = 0;
        while (!err && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("wd_edges_to_err", k, 32'd32);
        mode = 0;

        // Asynchronous reset in the middle of a divide
        do_reset();
        do_op("div_mid", 3'd2, 32'd100, 32'd7, 0);
        opValid = 1'b1;
        opCode  = 3'd5;
        repeat (3) @(negedge clk);
        chk("mid_stalling", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk("async_rst_stallCount", stallCount, 32'd0);
        opValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(32'd0);
        do_op("mflo_after_rst", 3'd5, '0, '0, 0);
        chk("post_rst_stallCount", stallCount, 32'd0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hlu_ctrl.md
# hlu_ctrl

Issue and interlock controller on the pipeline side of the HI/LO unit (HLU). It decodes the E-stage mult/div/mfhi/mflo/mthi/mtlo request and drives the HLU command port with single-cycle start pulses. It stalls the pipeline while the HLU is armed or busy and returns HI/LO read data. It also keeps a stall-cycle counter and a watchdog for a hung HLU.

## Interface
- `WD_LIMIT`, default 31: watchdog threshold, in cycles spent in ARMED/BUSY.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `opValid`  in  1: an HLU-class instruction is present in E.
- `opCode`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `rsData`, `rtData`  in  32: forwarded operands.
- `hluBusy`  in  1: HLU busy flag.
- `hluResult`  in  32: HLU result, HI when `hluDst`=1, else LO.
- `hluA`, `hluB`  out  32: HLU operands.
- `hluType`  out  4: 0001 multiply start, 0010 divide start, 0000 none.
- `hluUnsigned`  out  1: unsigned variant.
- `hluDst`  out  1: 1 selects HI.
- `hluWrite`  out  1: HI/LO write strobe.
- `stall`  out  1: freeze F/D/E this cycle.
- `rdValid`  out  1: `rdData` is valid for writeback (MFHI/MFLO accepted).
- `rdData`  out  32: read data.
- `stallCount`  out  32: stall cycles since reset, saturating.
- `err`  out  1: sticky watchdog error.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - ARMED: start sent; HLU busy not yet visible.
  - BUSY: HLU computing.
- `hluOp` = `opValid`. The stall rule is `stall` = `hluOp` & (state==ARMED | `hluBusy`). MTHI/MTLO/MFHI/MFLO are never issued while the HLU is busy. This prevents a write from being clobbered later by a pending result.
- Accept = `hluOp` & !`stall`. All HLU-drive outputs are 0 unless Accept holds. They are combinational, valid in the Accept cycle only.
  - MULT/MULTU: `hluType`=0001, `hluA`=`rsData`, `hluB`=`rtData`, `hluUnsigned`=opCode[0]. Next state ARMED.
  - DIV/DIVU: as above with `hluType`=0010. A divisor of 0 is still issued: the HLU goes busy and HI/LO keep their old values.
  - MTHI/MTLO: `hluWrite`=1, `hluA`=`rsData`, `hluDst`=(op==MTHI). State unchanged.
  - MFHI/MFLO: `hluDst`=(op==MFHI), `rdData`=`hluResult`, `rdValid`=1. State unchanged.
- Transitions:
  - ARMED → BUSY when `hluBusy`=1.
  - ARMED → IDLE with `err` set when `hluBusy` is still 0 (start lost).
  - BUSY with `hluBusy`=0 is treated as IDLE. A new start may be accepted that cycle (→ ARMED); otherwise → IDLE.
  - IDLE with a start accepted → ARMED.
- Watchdog: counter `wd` increments each cycle in ARMED/BUSY and clears in IDLE. At `wd`==WD_LIMIT: `err`<=1 and state → IDLE.
- `stallCount`: +1 per cycle with `stall`=1, saturating at 0xFFFFFFFF.

## Timing
- Reset (asynchronous): state IDLE, `wd`=0, `stallCount`=0, `err`=0. While reset is high, all HLU-drive outputs, `stall` and `rdValid` are forced to 0.
- The HLU resets synchronously. After reset deassertion, the controller treats `hluBusy` as authoritative.
- Start accepted at edge 0:
  - The HLU raises busy at edge 0.
  - Multiply: busy falls at edge 6, so a back-to-back HLU op stalls in cycles 1–6 (6 cycles) and is accepted at edge 7.
  - Divide: busy falls at edge 11; 11 stall cycles; accepted at edge 12.
- An MFHI/MFLO accepted at edge N returns `rdData` combinationally in cycle N. HI/LO are already updated because busy is low.
- Reset mid-operation: the FSM returns to IDLE immediately. `stall` drops in the same cycle.

## Structure
- Shared package/header:
  - opCode encodings (`OP_MULT`…`OP_MTLO`);
  - `HLU_START_MUL`=4'b0001, `HLU_START_DIV`=4'b0010, `HLU_NONE`=4'b0000;
  - FSM state encodings.
- One sub-module: `hlu_watchdog`, containing the `wd` counter, the WD_LIMIT compare and the sticky `err`. The rest is flat.

## Test plan
- MULT 7×(−3): accept at edge 0, immediate MFLO. Expect stall in cycles 1–6, then `rdData`=0xFFFFFFEB; MFHI then gives 0xFFFFFFFF; `stallCount`=6.
- DIVU 100/7 followed by MFHI. Expect 11 stall cycles, then `rdData`=2; MFLO gives 14.
- DIV by 0 after MTLO 0x1234 (accept in IDLE). The divide still stalls a following MFLO for 11 cycles; MFLO then gives 0x1234.
- MTHI 0xABCD presented in the cycle after a MULT accept (ARMED). Expect `stall`=1 and `hluWrite`=0 until busy falls. After acceptance, MFHI gives 0xABCD.
- Model the HLU with `hluBusy` stuck at 0 after a start. Expect `err`=1 one cycle after the start and the FSM in IDLE. With `hluBusy` stuck at 1, expect `err` when `wd`==31.
- Assert reset asynchronously mid-divide (between edges). Expect `stall`=0 and state IDLE before the next edge; `stallCount`=0.
